// File: rtl/output_layer_acc.sv
// output_layer_acc
//   Output-layer accumulator of the classifier datapath. One inference streams
//   N_INPUTS signed activations; each activation is multiplied by ten per-class
//   signed weights and accumulated, with saturation, onto per-class biases. The
//   ten signed class scores are presented packed on Num for the argmax stage.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   GlobalReset  synchronous active-high reset
//   Start        begin an inference (only honoured in IDLE)
//   Bias         NUM_SIZE*10 signed biases, slice k = class k, sampled on accepted Start
//   InValid      InData/Weights valid this cycle
//   InReady      block accepts a beat this cycle (high throughout ACC)
//   InData       IN_SIZE signed activation
//   Weights      W_SIZE*10 signed weights for the current activation, slice k = class k
//   Num          NUM_SIZE*10 signed class scores, slice k = class k
//   OutValid     Num holds a complete result (DONE)
//   OutReady     consumer takes the result
//   Busy         high in ACC or DONE
module output_layer_acc #(
  parameter int NUM_SIZE = 26,
  parameter int IN_SIZE  = 12,
  parameter int W_SIZE   = 10,
  parameter int N_INPUTS = 32
) (
  input  logic                  clk,
  input  logic                  GlobalReset,
  input  logic                  Start,
  input  logic [NUM_SIZE*10-1:0] Bias,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [IN_SIZE-1:0]    InData,
  input  logic [W_SIZE*10-1:0]  Weights,
  output logic [NUM_SIZE*10-1:0] Num,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  Busy
);

  localparam int NCLS   = 10;
  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam int PROD_W = IN_SIZE + W_SIZE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [NUM_SIZE-1:0] r_acc [NCLS];
  logic [CNT_W-1:0]    r_cnt;
  logic                w_beat;
  logic                w_last_beat;

  // Saturating multiply-accumulate. The sum is formed one bit wider than the
  // accumulator so that overflow shows up as a disagreement of the top two bits.
  function automatic logic [NUM_SIZE-1:0] sat_mac(
    input logic [NUM_SIZE-1:0] acc,
    input logic [IN_SIZE-1:0]  act,
    input logic [W_SIZE-1:0]   wgt
  );
    logic signed [PROD_W-1:0]   prod;
    logic        [NUM_SIZE:0]   sum;
    logic        [NUM_SIZE-1:0] res;
    prod = $signed(act) * $signed(wgt);
    sum  = {acc[NUM_SIZE-1], acc}
         + {{(NUM_SIZE + 1 - PROD_W){prod[PROD_W-1]}}, prod};
    if (sum[NUM_SIZE] != sum[NUM_SIZE-1]) begin
      // Overflow: clamp towards the sign of the true result.
      if (sum[NUM_SIZE]) begin
        res = {1'b1, {(NUM_SIZE-1){1'b0}}};
      end else begin
        res = {1'b0, {(NUM_SIZE-1){1'b1}}};
      end
    end else begin
      res = sum[NUM_SIZE-1:0];
    end
    return res;
  endfunction

  // InReady comes from the state register only, so a beat never depends
  // combinationally on InValid reaching InReady.
  assign w_beat      = InValid && InReady;
  assign w_last_beat = w_beat && (r_cnt == CNT_W'(N_INPUTS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) w_next_state = S_ACC;
        else       w_next_state = S_IDLE;
      end
      S_ACC: begin
        if (w_last_beat) w_next_state = S_DONE;
        else             w_next_state = S_ACC;
      end
      S_DONE: begin
        // OutValid is constant high here, so OutReady alone completes the handshake.
        if (OutReady) w_next_state = S_IDLE;
        else          w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    InReady  = 1'b0;
    OutValid = 1'b0;
    Busy     = 1'b0;
    case (r_state)
      S_ACC: begin
        InReady = 1'b1;
        Busy    = 1'b1;
      end
      S_DONE: begin
        OutValid = 1'b1;
        Busy     = 1'b1;
      end
      default: begin
        InReady  = 1'b0;
        OutValid = 1'b0;
        Busy     = 1'b0;
      end
    endcase
  end

  // Accumulators and beat counter: bias load on Start, MAC on each accepted beat.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      for (int k = 0; k < NCLS; k++) r_acc[k] <= {NUM_SIZE{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            for (int k = 0; k < NCLS; k++) r_acc[k] <= Bias[k*NUM_SIZE +: NUM_SIZE];
            r_cnt <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_ACC: begin
          if (w_beat) begin
            for (int k = 0; k < NCLS; k++)
              r_acc[k] <= sat_mac(r_acc[k], InData, Weights[k*W_SIZE +: W_SIZE]);
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Scores are the accumulator registers themselves; they only hold a
  // meaningful result while OutValid is high.
  for (genvar g = 0; g < NCLS; g++) begin : g_num
    assign Num[g*NUM_SIZE +: NUM_SIZE] = r_acc[g];
  end

endmodule
